// File: rtl/synch_queue_if.sv
// Handshake and status bundle between a producer/consumer stage and synch_queue.
interface synch_queue_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  iFlush;
   logic                  iPush;
   logic [DATA_WIDTH-1:0] iDataIn;
   logic                  iPop;
   logic [DATA_WIDTH-1:0] oDataOut;
   logic [ADDR_WIDTH:0]   oCount;
   logic                  oFull;
   logic                  oEmpty;
   logic                  oAlmostFull;
   logic                  oAlmostEmpty;
   logic                  oOverflow;
   logic                  oUnderflow;

   modport master (
      output iFlush, iPush, iDataIn, iPop,
      input  oDataOut, oCount, oFull, oEmpty, oAlmostFull, oAlmostEmpty, oOverflow, oUnderflow
   );

   modport slave (
      input  iFlush, iPush, iDataIn, iPop,
      output oDataOut, oCount, oFull, oEmpty, oAlmostFull, oAlmostEmpty, oOverflow, oUnderflow
   );
endinterface

// File: rtl/synch_queue.sv
// Single-clock show-ahead queue, FIFO or LIFO ordering chosen at elaboration,
// with occupancy, threshold flags and sticky overflow/underflow errors.
module synch_queue #(
   parameter int unsigned DATA_WIDTH         = 32,
   parameter int unsigned ADDR_WIDTH         = 4,
   parameter int unsigned MEM_SIZE           = 16,
   parameter int unsigned LIFO_MODE          = 0,
   parameter int unsigned ALMOST_FULL_LEVEL  = MEM_SIZE - 2,
   parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
   input  logic        iClock,
   input  logic        iReset,
   synch_queue_if.slave q_if
);

   localparam int unsigned CW      = ADDR_WIDTH + 1;
   localparam bit          IS_LIFO = (LIFO_MODE != 0);

   localparam logic [CW-1:0]         SIZE_C  = CW'(MEM_SIZE);
   localparam logic [CW-1:0]         AFULL_C = CW'(ALMOST_FULL_LEVEL);
   localparam logic [CW-1:0]         AEMPT_C = CW'(ALMOST_EMPTY_LEVEL);
   localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(MEM_SIZE - 1);

   logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   logic                  we_c;
   logic [ADDR_WIDTH-1:0] waddr_c;
   logic [ADDR_WIDTH-1:0] raddr_c;
   logic                  empty_c;
   logic                  full_c;

   // Wrap explicitly so non-power-of-two depths work.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == LAST_C) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   assign empty_c = (count_q == '0);
   assign full_c  = (count_q == SIZE_C);
   assign raddr_c = IS_LIFO ? ADDR_WIDTH'(count_q - CW'(1)) : rd_ptr_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      we_c     = 1'b0;
      waddr_c  = IS_LIFO ? ADDR_WIDTH'(count_q) : wr_ptr_q;

      if (q_if.iFlush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         unique case ({q_if.iPush, q_if.iPop})
            2'b11: begin
               we_c = 1'b1;
               if (empty_c) begin
                  // Pop on empty is dropped; the push still lands.
                  count_d = CW'(1);
                  udf_d   = 1'b1;
                  if (!IS_LIFO) wr_ptr_d = ptr_inc(wr_ptr_q);
               end else if (IS_LIFO) begin
                  waddr_c = raddr_c;
               end else begin
                  wr_ptr_d = ptr_inc(wr_ptr_q);
                  rd_ptr_d = ptr_inc(rd_ptr_q);
               end
            end
            2'b10: begin
               if (full_c) begin
                  ovf_d = 1'b1;
               end else begin
                  we_c    = 1'b1;
                  count_d = count_q + CW'(1);
                  if (!IS_LIFO) wr_ptr_d = ptr_inc(wr_ptr_q);
               end
            end
            2'b01: begin
               if (empty_c) begin
                  udf_d = 1'b1;
               end else begin
                  count_d = count_q - CW'(1);
                  if (!IS_LIFO) rd_ptr_d = ptr_inc(rd_ptr_q);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is not reset; emptiness is tracked by the count alone.
   always_ff @(posedge iClock) begin
      if (we_c && !iReset && !q_if.iFlush) mem_q[waddr_c] <= q_if.iDataIn;
   end

   assign q_if.oDataOut     = empty_c ? '0 : mem_q[raddr_c];
   assign q_if.oCount       = count_q;
   assign q_if.oFull        = full_c;
   assign q_if.oEmpty       = empty_c;
   assign q_if.oAlmostFull  = (count_q >= AFULL_C);
   assign q_if.oAlmostEmpty = (count_q <= AEMPT_C);
   assign q_if.oOverflow    = ovf_q;
   assign q_if.oUnderflow   = udf_q;

endmodule
